// File: rtl/dec3to8_hs.sv
// Registered 3-to-8 decoder with ready/valid intake and per-line ack handshake.
// A decoded line stays high until its consumer acks it, EN drops, or the timeout expires.
module dec3to8_hs #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [2:0]       Y,
    input  logic             valid,
    output logic             ready,
    output logic [7:0]       Dout,
    input  logic [7:0]       ack,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [2:0]       code_r, code_s;
    logic [TW-1:0]    timer_r, timer_s;
    logic [7:0]       dout_r, dout_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             terr_r, terr_s;

    function automatic logic [7:0] onehot8(input logic [2:0] c);
        onehot8 = 8'd1 << c;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            code_r  <= 3'd0;
            timer_r <= {TW{1'b0}};
            dout_r  <= 8'd0;
            cnt_r   <= {CNT_W{1'b0}};
            terr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            code_r  <= code_s;
            timer_r <= timer_s;
            dout_r  <= dout_s;
            cnt_r   <= cnt_s;
            terr_r  <= terr_s;
        end
    end

    // Next-state and next-datapath logic; abort beats ack, ack beats timeout.
    always_comb begin
        state_s = state_r;
        code_s  = code_r;
        timer_s = timer_r;
        dout_s  = dout_r;
        cnt_s   = cnt_r;
        terr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid && ready) begin
                    code_s  = Y;
                    dout_s  = onehot8(Y);
                    timer_s = {TW{1'b0}};
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (!EN) begin
                    dout_s  = 8'd0;
                    state_s = IDLE;
                end else if (ack[code_r]) begin
                    dout_s  = 8'd0;
                    cnt_s   = cnt_r + CNT_W'(1);
                    state_s = RECOVER;
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    dout_s  = 8'd0;
                    terr_s  = 1'b1;
                    state_s = RECOVER;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            RECOVER: begin
                state_s = IDLE;
            end
            default: begin
                dout_s  = 8'd0;
                state_s = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register; ready also gates on EN and rst.
    always_comb begin
        if (state_r == IDLE) begin
            ready = EN & ~rst;
            busy  = 1'b0;
        end else if ((state_r == DRIVE) || (state_r == RECOVER)) begin
            ready = 1'b0;
            busy  = 1'b1;
        end else begin
            ready = 1'b0;
            busy  = 1'b0;
        end
    end

    assign Dout        = dout_r;
    assign timeout_err = terr_r;
    assign done_cnt    = cnt_r;

endmodule

// File: tb/tb_dec3to8_hs.sv
// Self-checking bench for dec3to8_hs: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dec3to8_hs;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             EN = 1'b1;
    logic [2:0]       Y = 3'd5;
    logic             valid = 1'b1;
    logic             ready;
    logic [7:0]       Dout;
    logic [7:0]       ack = 8'd0;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] done_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    dec3to8_hs #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .EN(EN), .Y(Y), .valid(valid), .ready(ready),
        .Dout(Dout), .ack(ack), .busy(busy), .timeout_err(timeout_err),
        .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which line is being driven (-1 none), for how many cycles, and
    // whether the mandatory low gap cycle is pending.
    int  m_code = -1;
    int  m_age  = 0;
    bit  m_gap  = 1'b0;
    int  m_cnt  = 0;
    bit  m_terr = 1'b0;
    bit  mdl_ok = 1'b0;

    always @(posedge clk) begin
        m_terr = 1'b0;
        if (rst) begin
            m_code = -1; m_age = 0; m_gap = 1'b0; m_cnt = 0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_code < 0) begin
            if (valid && EN) begin
                m_code = int'(Y);
                m_age  = 0;
            end
        end else begin
            m_age++;
            if (!EN) begin
                m_code = -1;
            end else if (ack[m_code]) begin
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                m_code = -1;
                m_gap  = 1'b1;
            end else if (m_age == TIMEOUT) begin
                m_terr = 1'b1;
                m_code = -1;
                m_gap  = 1'b1;
            end
        end
        mdl_ok = 1'b1;
    end

    int hi_run = 0;
    int last_run = 0;
    int terr_seen = 0;

    // Per-cycle comparison against the model, plus pulse-length bookkeeping.
    always @(negedge clk) begin
        if (mdl_ok) begin
            check("dout", Dout, (m_code >= 0) ? (64'd1 << m_code) : 64'd0);
            check("busy", busy, (m_code >= 0) || m_gap);
            check("ready", ready, (m_code < 0) && !m_gap && EN && !rst);
            check("timeout_err", timeout_err, m_terr);
            check("done_cnt", done_cnt, m_cnt);
            check("onehot", ($countones(Dout) <= 1), 1);
        end
        if (timeout_err) terr_seen++;
        if (Dout != 8'd0) begin
            hi_run++;
        end else if (hi_run > 0) begin
            last_run = hi_run;
            hi_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    longint t_acc[8];
    int r;
    int d;

    initial begin
        // Reset held two cycles with a pending request.
        tick(); tick();
        check("rst_dout", Dout, 0);
        check("rst_cnt", done_cnt, 0);
        check("rst_ready", ready, 0);
        rst = 1'b0; valid = 1'b0;
        #1;
        check("ready_after_rst", ready, 1);

        // Sweep every code with ack on the first drive cycle.
        for (int y = 0; y < 8; y++) begin
            valid = 1'b1; Y = 3'(y);
            tick();
            t_acc[y] = $time;
            check("sweep_dout", Dout, 64'd1 << y);
            valid = 1'b0; ack = 8'd1 << y;
            tick();
            ack = 8'd0;
            tick();
        end
        for (int y = 1; y < 8; y++) check("accept_spacing", t_acc[y] - t_acc[y-1], 30);
        check("sweep_cnt", done_cnt, 8);
        check("sweep_no_terr", terr_seen, 0);

        // Wrong acks only: line must time out after exactly TIMEOUT cycles.
        valid = 1'b1; Y = 3'd3;
        tick();
        valid = 1'b0; ack = 8'b1111_0111;
        repeat (20) tick();
        ack = 8'd0;
        check("timeout_len", last_run, 15);
        check("timeout_pulses", terr_seen, 1);
        check("timeout_cnt", done_cnt, 8);

        // Ack arrives on the last allowed drive cycle: ack wins.
        valid = 1'b1; Y = 3'd6;
        tick();
        valid = 1'b0;
        repeat (14) tick();
        ack = 8'd1 << 6;
        tick();
        ack = 8'd0;
        check("collide_dout", Dout, 0);
        check("collide_cnt", done_cnt, 9);
        tick(); tick();
        check("collide_no_terr", terr_seen, 1);
        check("collide_len", last_run, 15);

        // Abort by dropping EN on drive cycle 4.
        valid = 1'b1; Y = 3'd2;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        EN = 1'b0;
        tick();
        check("abort_dout", Dout, 0);
        check("abort_busy", busy, 0);
        EN = 1'b1;
        tick();
        check("abort_cnt", done_cnt, 9);
        check("abort_no_terr", terr_seen, 1);

        // Same point, but reset instead.
        valid = 1'b1; Y = 3'd2;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst_dout", Dout, 0);
        check("midrst_cnt", done_cnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_terr", timeout_err, 0);
        rst = 1'b0;
        tick();

        // 256 acknowledged transactions with noise: counter must wrap to zero.
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 7);
            valid = 1'b1; Y = 3'(r);
            tick();
            d = $urandom_range(0, 3);
            repeat (d) begin
                valid = 1'($urandom); Y = 3'($urandom);
                ack = 8'($urandom) & ~(8'd1 << r);
                tick();
            end
            ack = 8'($urandom) | (8'd1 << r);
            tick();
            ack = 8'd0; valid = 1'($urandom); Y = 3'($urandom);
            tick();
        end
        check("wrap_cnt", done_cnt, 0);

        // Fully random traffic including EN drops and occasional resets.
        repeat (600) begin
            rst   = ($urandom_range(0, 99) == 0);
            EN    = ($urandom_range(0, 9) != 0);
            valid = 1'($urandom);
            Y     = 3'($urandom);
            ack   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
            tick();
        end
        rst = 1'b0; EN = 1'b1; valid = 1'b0; ack = 8'd0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
